// File: rtl/random_deinterleaver_pkg.sv
// Shared definitions for the LFSR random interleaver/deinterleaver pair: FSM states,
// Fibonacci LFSR tap masks and the LFSR next-state function (widths 2..16).
package random_interleave_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        PERM = 1'b1
    } state_t;

    localparam int LFSR_W_MAX = 16;

    // Maximal-length tap sets; bit (t-1) is set for polynomial term x^t.
    function automatic logic [LFSR_W_MAX-1:0] lfsr_taps(input int width);
        logic [LFSR_W_MAX-1:0] mask;
        mask = '0;
        case (width)
            2:       mask = 16'h0003;
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = '0;
        endcase
        return mask;
    endfunction

    function automatic logic [LFSR_W_MAX-1:0] lfsr_next(input logic [LFSR_W_MAX-1:0] state,
                                                        input int width);
        logic                  fb;
        logic [LFSR_W_MAX-1:0] keep;
        fb   = ^(state & lfsr_taps(width));
        keep = (LFSR_W_MAX'(1) << width) - LFSR_W_MAX'(1);
        return {state[LFSR_W_MAX-2:0], fb} & keep;
    endfunction

endpackage

// File: rtl/random_deinterleaver_if.sv
// Bit-stream handshake bundle for the random deinterleaver: serial input side,
// serial output side and the end-of-block pulse.
interface random_deinterleaver_if;
    logic in_data;
    logic in_valid;
    logic in_ready;
    logic out_data;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, done
    );
endinterface

// File: rtl/random_deinterleaver_lfsr_perm_gen.sv
// LFSR permutation generator shared by the interleaver and deinterleaver:
// walks the LFSR sequence from SEED and flags states that map into the block.
module lfsr_perm_gen
    import random_interleave_pkg::*;
#(
    parameter int N      = 1024,
    parameter int LFSR_W = 11,
    parameter int SEED   = 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  load,
    input  logic                                  advance,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] index,
    output logic                                  index_valid
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (LFSR_W < 2 || LFSR_W > LFSR_W_MAX || (2**LFSR_W) - 1 < N ||
        SEED < 1 || SEED > (2**LFSR_W) - 1) begin : g_bad_cfg
        $error("lfsr_perm_gen: LFSR_W/SEED cannot cover a block of N bits");
    end

    // Upper bits stay zero; lfsr_next masks them to LFSR_W.
    logic [LFSR_W_MAX-1:0] state_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LFSR_W_MAX'(SEED);
        end else if (load) begin
            state_q <= LFSR_W_MAX'(SEED);
        end else if (advance) begin
            state_q <= lfsr_next(state_q, LFSR_W);
        end
    end

    assign index       = IDX_W'(state_q - LFSR_W_MAX'(1));
    assign index_valid = (state_q <= LFSR_W_MAX'(N));

endmodule

// File: rtl/random_deinterleaver.sv
// Random bit deinterleaver: buffers an N-bit block, then emits buf[p(k)] in LFSR order.
// Define DOUBLE_BUF_EN for ping-pong banks so loading overlaps readout.
module random_deinterleaver
    import random_interleave_pkg::*;
#(
    parameter int N      = 1024,
    parameter int LFSR_W = 11,
    parameter int SEED   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    random_deinterleaver_if.slave bus
);

    localparam int                CNT_W    = $clog2(N + 1);
    localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
    logic             live_q;
    logic             out_data_q, out_valid_q, out_last_q, done_q;
    logic             in_ready, in_fire, out_fire, wr_last, drained;
    logic             perm_active, load_ok, emit, gen_load, gen_adv;
    logic [IDX_W-1:0] perm_idx, wr_idx;
    logic             perm_vld, rd_bit;
    logic [N-1:0]     bank0;

    assign in_fire     = bus.in_valid & in_ready;
    assign out_fire    = out_valid_q & bus.out_ready;
    assign wr_last     = (wr_cnt_q == LAST_CNT);
    assign wr_idx      = IDX_W'(wr_cnt_q);
    assign drained     = out_fire & out_last_q;
    assign perm_active = (state_q == PERM) && (rd_cnt_q != FULL_CNT);
    assign load_ok     = !out_valid_q || bus.out_ready;
    assign emit        = perm_active & perm_vld & load_ok;
    // Skip states always advance; in-range states wait for room in the output register.
    assign gen_adv     = perm_active & (!perm_vld | load_ok);

`ifdef DOUBLE_BUF_EN
    logic [N-1:0] bank1;
    logic         wr_sel_q, wr_full_q, swap;

    assign in_ready = live_q & !wr_full_q;
    // A completing write and a draining read in the same cycle swap with no gap.
    assign swap     = (wr_full_q | (in_fire & wr_last)) & ((state_q == LOAD) | drained);
    assign gen_load = swap;
    assign rd_bit   = wr_sel_q ? bank0[perm_idx] : bank1[perm_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_sel_q  <= 1'b0;
            wr_full_q <= 1'b0;
        end else if (swap) begin
            wr_sel_q  <= ~wr_sel_q;
            wr_full_q <= 1'b0;
        end else if (in_fire && wr_last) begin
            wr_full_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (in_fire) begin
            if (wr_sel_q) begin
                bank1[wr_idx] <= bus.in_data;
            end else begin
                bank0[wr_idx] <= bus.in_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (swap) begin
            state_d = PERM;
        end else if (drained) begin
            state_d = LOAD;
        end
    end
`else
    assign in_ready = live_q & (state_q == LOAD);
    assign gen_load = in_fire & wr_last;
    assign rd_bit   = bank0[perm_idx];

    always_ff @(posedge clock) begin
        if (in_fire) begin
            bank0[wr_idx] <= bus.in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (gen_load) state_d = PERM;
            PERM:    if (drained)  state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    lfsr_perm_gen #(
        .N      (N),
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_perm_gen (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (gen_load),
        .advance     (gen_adv),
        .index       (perm_idx),
        .index_valid (perm_vld)
    );

    // Output stage: single register, held while the sink stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            live_q      <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_data_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            live_q <= 1'b1;
            done_q <= drained;
            if (in_fire) begin
                wr_cnt_q <= wr_last ? '0 : wr_cnt_q + CNT_W'(1);
            end
            if (drained) begin
                rd_cnt_q <= '0;
            end else if (emit) begin
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
            if (emit) begin
                out_data_q  <= rd_bit;
                out_valid_q <= 1'b1;
                out_last_q  <= (rd_cnt_q == LAST_CNT);
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_random_deinterleaver.sv
// Directed bench for random_deinterleaver with N=8, LFSR_W=4, SEED=1 (p = 0,1,3,2,5,4,6,7).
module tb_random_deinterleaver;

    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;

    random_deinterleaver_if bus ();

    random_deinterleaver #(
        .N      (8),
        .LFSR_W (4),
        .SEED   (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  got;
        int          n;
        int          last_at;
        int          dones;
        logic [15:0] vpat;
        int          done_edge;
        int          stall_err;
        int          rdy_hi;
        logic        rdy_at_done;
    } perm_res_t;

    task automatic load_block(input logic [7:0] bits, input int count, input bit hold);
        int guard;
        for (int i = 0; i < count; i++) begin
            bus.in_data  = bits[i];
            bus.in_valid = 1'b1;
            guard = 0;
            while (!bus.in_ready && guard < 64) begin
                @(posedge clock); #1;
                guard++;
            end
            if (guard >= 64) begin
                vectors++;
                miscompares++;
                $display("FAIL load_ready_timeout: bit %0d never accepted, in_ready=%0b required 1", i, bus.in_ready);
            end
            @(posedge clock); #1;
        end
        if (hold) begin
            bus.in_data = 1'b1;
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    // Drives out_ready (always 1, or toggling 0/1) and collects the consumed bits.
    task automatic run_perm(input bit toggle, output perm_res_t r);
        logic pv, pd, pl, rdy;
        r.got = '0; r.n = 0; r.last_at = -1; r.dones = 0; r.vpat = '0;
        r.done_edge = -1; r.stall_err = 0; r.rdy_hi = 0; r.rdy_at_done = 1'b0;
        pv = bus.out_valid; pd = bus.out_data; pl = bus.out_last;
        for (int e = 1; e <= 60 && r.dones == 0; e++) begin
            rdy = toggle ? ((e % 2) == 0) : 1'b1;
            bus.out_ready = rdy;
            @(posedge clock); #1;
            if (pv && rdy) begin
                if (r.n < 8) r.got[r.n] = pd;
                if (pl) r.last_at = r.n;
                r.n++;
            end else if (pv && !rdy) begin
                if (!bus.out_valid || bus.out_data !== pd || bus.out_last !== pl) r.stall_err++;
            end
            if (e <= 16) r.vpat[e-1] = bus.out_valid;
            if (bus.done) begin
                r.dones++;
                r.done_edge = e;
                r.rdy_at_done = bus.in_ready;
                bus.in_valid = 1'b0;
            end else if (bus.in_ready) begin
                r.rdy_hi++;
            end
            pv = bus.out_valid; pd = bus.out_data; pl = bus.out_last;
        end
        bus.out_ready = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clock); #1;
            if (bus.done) r.dones++;
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
        vectors++; if (bus.out_data !== 1'b0) begin miscompares++; $display("FAIL rst_out_data: got %0b want 0", bus.out_data); end
        vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last: got %0b want 0", bus.out_last); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %0b want 0", bus.done); end
        #10 reset_n = 1'b1;
        @(posedge clock); #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_single_one();
        perm_res_t r;
        load_block(8'b0000_1000, 8, 1'b0);
`ifndef DOUBLE_BUF_EN
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL one_perm_ready: got %0b want 0", bus.in_ready); end
`endif
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL one_first_valid: got %0b want 0", bus.out_valid); end
        run_perm(1'b0, r);
        vectors++; if (r.got !== 8'b0000_0100) begin miscompares++; $display("FAIL one_data: got %b want 00000100", r.got); end
        vectors++; if (r.n !== 8) begin miscompares++; $display("FAIL one_count: got %0d want 8", r.n); end
        vectors++; if (r.last_at !== 7) begin miscompares++; $display("FAIL one_last: got %0d want 7", r.last_at); end
        vectors++; if (r.dones !== 1) begin miscompares++; $display("FAIL one_done: got %0d want 1", r.dones); end
    endtask

    task automatic test_perm_timing();
        perm_res_t r;
        load_block(8'b0100_1101, 8, 1'b0);
        run_perm(1'b0, r);
        vectors++; if (r.got !== 8'b0100_1101) begin miscompares++; $display("FAIL tim_data: got %b want 01001101", r.got); end
        vectors++; if (r.vpat !== 16'h4537) begin miscompares++; $display("FAIL tim_valid_pattern: got %h want 4537", r.vpat); end
        vectors++; if (r.done_edge !== 16) begin miscompares++; $display("FAIL tim_done_edge: got %0d want 16", r.done_edge); end
        vectors++; if (r.dones !== 1) begin miscompares++; $display("FAIL tim_done: got %0d want 1", r.dones); end
    endtask

    task automatic test_backpressure();
        perm_res_t r;
        load_block(8'b0001_0100, 8, 1'b0);
        run_perm(1'b1, r);
        vectors++; if (r.got !== 8'b0010_1000) begin miscompares++; $display("FAIL bp_data: got %b want 00101000", r.got); end
        vectors++; if (r.n !== 8) begin miscompares++; $display("FAIL bp_count: got %0d want 8", r.n); end
        vectors++; if (r.stall_err !== 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable stalls want 0", r.stall_err); end
        vectors++; if (r.last_at !== 7) begin miscompares++; $display("FAIL bp_last: got %0d want 7", r.last_at); end
        vectors++; if (r.dones !== 1) begin miscompares++; $display("FAIL bp_done: got %0d want 1", r.dones); end
    endtask

`ifndef DOUBLE_BUF_EN
    task automatic test_hold_valid();
        perm_res_t r;
        load_block(8'b0000_0110, 8, 1'b1);
        run_perm(1'b0, r);
        vectors++; if (r.got !== 8'b0000_1010) begin miscompares++; $display("FAIL hold_data: got %b want 00001010", r.got); end
        vectors++; if (r.rdy_hi !== 0) begin miscompares++; $display("FAIL hold_ready_in_perm: got %0d ready cycles want 0", r.rdy_hi); end
        vectors++; if (r.rdy_at_done !== 1'b1) begin miscompares++; $display("FAIL hold_ready_at_done: got %0b want 1", r.rdy_at_done); end
        load_block(8'b0001_0100, 8, 1'b0);
        run_perm(1'b0, r);
        vectors++; if (r.got !== 8'b0010_1000) begin miscompares++; $display("FAIL hold_next_data: got %b want 00101000", r.got); end
        vectors++; if (r.dones !== 1) begin miscompares++; $display("FAIL hold_next_done: got %0d want 1", r.dones); end
    endtask
`endif

    task automatic test_mid_reset();
        perm_res_t r;
        load_block(8'b1111_1111, 5, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready: got %0b want 0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %0b want 0", bus.out_valid); end
        @(posedge clock);
        @(posedge clock);
        #1;
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done: got %0b want 0", bus.done); end
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_release_ready: got %0b want 1", bus.in_ready); end
        load_block(8'b0010_0110, 8, 1'b0);
        run_perm(1'b0, r);
        vectors++; if (r.got !== 8'b0001_1010) begin miscompares++; $display("FAIL mid_rst_data: got %b want 00011010", r.got); end
        vectors++; if (r.dones !== 1) begin miscompares++; $display("FAIL mid_rst_done_count: got %0d want 1", r.dones); end
    endtask

`ifdef DOUBLE_BUF_EN
    task automatic test_double_buf();
        logic [23:0] src, exp, got;
        int          n_got, dones;
        logic        pv, pd;
        src = {8'b0010_0110, 8'b0001_0100, 8'b0000_1000};
        exp = {8'b0001_1010, 8'b0010_1000, 8'b0000_0100};
        got = '0; n_got = 0; dones = 0; pv = 1'b0; pd = 1'b0;
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    bus.in_data  = src[i];
                    bus.in_valid = 1'b1;
                    for (int g = 0; g < 200 && !bus.in_ready; g++) begin
                        @(posedge clock); #1;
                    end
                    @(posedge clock); #1;
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 300; c++) begin
                    @(posedge clock); #1;
                    if (pv && n_got < 24) begin
                        got[n_got] = pd;
                        n_got++;
                    end
                    if (bus.done) dones++;
                    pv = bus.out_valid;
                    pd = bus.out_data;
                end
            end
        join
        bus.out_ready = 1'b0;
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL dbl_data: got %h want %h", got, exp); end
        vectors++; if (n_got !== 24) begin miscompares++; $display("FAIL dbl_count: got %0d want 24", n_got); end
        vectors++; if (dones !== 3) begin miscompares++; $display("FAIL dbl_done: got %0d want 3", dones); end
    endtask
`endif

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset_n       = 1'b0;
        bus.in_data   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_one();
        test_perm_timing();
        test_backpressure();
`ifndef DOUBLE_BUF_EN
        test_hold_valid();
`endif
        test_mid_reset();
`ifdef DOUBLE_BUF_EN
        test_double_buf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
